// File: rtl/sr_cmd_gen.sv
// Set/clear command generator for a downstream SR flip-flop.
// Each button is synchronised, debounced and edge-detected; an arbiter issues exclusive S/R pulses.
module sr_cmd_gen #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic conflict,
    output logic state
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Channel index 0 is set, index 1 is clear.
    logic [1:0]    btn;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    db_q;
    logic [1:0]    db_d;
    logic [1:0]    rise;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    logic s_q, s_d;
    logic r_q, r_d;
    logic conflict_q, conflict_d;
    logic state_q, state_d;

    assign btn = {clr_btn, set_btn};

    always_comb begin
        db_d     = db_q;
        cnt_d[0] = cnt_q[0];
        cnt_d[1] = cnt_q[1];
        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] == db_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                db_d[ch]  = sync2_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CW'(1);
            end
        end
    end

    // Edge taken from next-state so the command registers on the same edge db rises.
    assign rise = db_d & ~db_q;

    always_comb begin
        s_d        = rise[0] & ~rise[1];
        r_d        = rise[1] & ~rise[0];
        conflict_d = rise[0] & rise[1];
        state_d    = state_q;
        if (s_d) begin
            state_d = 1'b1;
        end else if (r_d) begin
            state_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            state_q    <= 1'b0;
        end else begin
            sync1_q    <= btn;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            state_q    <= state_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign conflict = conflict_q;
    assign state    = state_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen (DB_CYCLES=4): expected pulse edges are hand-computed per step.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic rst;
  logic set_btn;
  logic clr_btn;
  logic S;
  logic R;
  logic conflict;
  logic state;

  int tests = 0;
  int fails = 0;

  sr_cmd_gen #(.DB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_btn  (set_btn),
    .clr_btn  (clr_btn),
    .S        (S),
    .R        (R),
    .conflict (conflict),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  // Advance n edges; s_at/r_at/c_at give the 1-based edge after which that pulse
  // is expected (0 = never). state starts at st0 and follows the S/R pulses.
  task automatic run(input string tag, input int n, input int s_at, input int r_at,
                     input int c_at, input logic st0);
    logic st;
    st = st0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == s_at) st = 1'b1;
      if (k == r_at) st = 1'b0;
      check({tag, ".S"}, k, S, logic'(k == s_at));
      check({tag, ".R"}, k, R, logic'(k == r_at));
      check({tag, ".conflict"}, k, conflict, logic'(k == c_at));
      check({tag, ".state"}, k, state, st);
      check({tag, ".s_and_r"}, k, S & R, 1'b0);
    end
  endtask

  initial begin
    logic [4:0] bounce;
    bounce  = 5'b10101;
    rst     = 1'b0;
    set_btn = 1'b0;
    clr_btn = 1'b0;

    // Reset held for 3 edges with buttons toggling.
    for (int i = 0; i < 3; i++) begin
      set_btn = ~set_btn;
      clr_btn = logic'($urandom_range(0, 1));
      run("reset", 1, 0, 0, 0, 1'b0);
    end
    set_btn = 1'b0;
    clr_btn = 1'b0;
    rst     = 1'b1;
    run("reset_release", 8, 0, 0, 0, 1'b0);

    // Clean press: S after E6, state 1 from E6.
    set_btn = 1'b1;
    run("press", 20, 6, 0, 0, 1'b0);
    set_btn = 1'b0;
    run("press_release", 10, 0, 0, 0, 1'b1);

    // Bounce on clear: 1,0,1,0,1 then hold; R six edges after the final 1.
    for (int i = 0; i < 5; i++) begin
      clr_btn = bounce[4 - i];
      run("bounce", 1, 0, 0, 0, 1'b1);
    end
    run("bounce_hold", 12, 0, 5, 0, 1'b1);
    clr_btn = 1'b0;
    run("bounce_release", 10, 0, 0, 0, 1'b0);

    // Staggered: set, then clear two cycles later.
    set_btn = 1'b1;
    run("stagger_a", 2, 0, 0, 0, 1'b0);
    clr_btn = 1'b1;
    run("stagger_b", 10, 4, 6, 0, 1'b0);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    run("stagger_release", 10, 0, 0, 0, 1'b0);

    // Bring state to 1, then both buttons at once.
    set_btn = 1'b1;
    run("pre_sim", 10, 6, 0, 0, 1'b0);
    set_btn = 1'b0;
    run("pre_sim_release", 10, 0, 0, 0, 1'b1);
    set_btn = 1'b1;
    clr_btn = 1'b1;
    run("simultaneous", 14, 0, 0, 6, 1'b1);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    run("sim_release", 10, 0, 0, 0, 1'b1);

    // Reset mid-debounce: press, reset at E4, release at E5 with button held.
    set_btn = 1'b1;
    run("rstmid_pre", 3, 0, 0, 0, 1'b1);
    rst = 1'b0;
    run("rstmid_rst", 1, 0, 0, 0, 1'b0);
    rst = 1'b1;
    run("rstmid_post", 12, 6, 0, 0, 1'b0);
    set_btn = 1'b0;
    run("rstmid_release", 10, 0, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command generator that sits directly upstream of the SR flip-flop stage. It takes two raw, asynchronous push-button inputs (set and clear), synchronises and debounces each one, and detects debounced rising edges. It then drives mutually exclusive single-cycle `S`/`R` command pulses into the flip-flop. Its `S`/`R` outputs are never asserted together, and it flags simultaneous requests rather than forwarding the illegal `11` code.

## Interface
- `DB_CYCLES`, default 4: consecutive sampled cycles a synchronised input must differ from its debounced value before that value flips. Legal range is ≥1. The counter is sized internally to hold `DB_CYCLES-1`.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-low (asserted when 0, sampled on `clk` rising edge).
- `set_btn` input, 1 bit: raw set request, asynchronous, may bounce.
- `clr_btn` input, 1 bit: raw clear request, asynchronous, may bounce.
- `S` output, 1 bit: registered one-cycle set command to the downstream flip-flop.
- `R` output, 1 bit: registered one-cycle reset command to the downstream flip-flop.
- `conflict` output, 1 bit: registered one-cycle flag indicating simultaneous set and clear edges that were dropped.
- `state` output, 1 bit: registered shadow of the expected downstream `q`.

## Operation
- There are two identical channels (set and clear), each with a synchroniser, a debouncer and an edge detector, followed by a shared arbiter.
- Synchroniser: 2-flop chain `sync1 <= btn`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Debouncer per channel: a debounced bit `db` and a counter `cnt`.
  - If `sync2 == db`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `db <= sync2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- A glitch on `sync2` shorter than `DB_CYCLES` consecutive samples never changes `db`.
- Rising edge: `rise` is true at the edge where `db` updates 0→1. It is computed from next-state, so the command registers at that same edge. Falling edges of `db` generate nothing.
- Arbiter, evaluated at every edge:
  - Set rise only: `S <= 1`, `R <= 0`, `conflict <= 0`, `state <= 1`.
  - Clear rise only: `R <= 1`, `S <= 0`, `conflict <= 0`, `state <= 0`.
  - Both rises at the same edge: `S <= 0`, `R <= 0`, `conflict <= 1`, `state` unchanged.
  - Neither: `S`, `R` and `conflict` all 0; `state` holds.
- `S` and `R` are never both 1 in any cycle. This is a required invariant.
- A held button produces exactly one pulse. A new pulse requires `db` to fall (debounced release) and rise again.

## Timing
- Reset (`rst == 0` at an edge) clears everything. The following are all 0 after that edge: `sync1`, `sync2`, `db`, `cnt` (both channels), `S`, `R`, `conflict`, `state`.
- Reset has priority over all other activity.
- Reset mid-debounce discards the partial count.
- Reset mid-pulse deasserts `S`/`R` at that edge.
- Button held through reset release: `db` restarts at 0, so a single `S`/`R` pulse is generated after the normal latency.
- Latency, with the raw input stable before edge E1:
  - `sync2` valid after E2.
  - The counter samples at E3..E(2+`DB_CYCLES`).
  - `S`/`R` is high during the cycle after edge E(2+`DB_CYCLES`). For `DB_CYCLES=4`, that is after edge E6.
- All pulses (`S`, `R`, `conflict`) are exactly 1 cycle wide.
- `state` changes at the same edge that `S`/`R` asserts.
- `DB_CYCLES=1`: `db` follows `sync2` one edge later, giving a total latency of 3 edges.
- Counter wrap: `cnt` never exceeds `DB_CYCLES-1`, so no overflow is possible.

## Test plan
- Reset: hold `rst=0` for 3 edges with both buttons toggling → `S`, `R`, `conflict` and `state` are all 0 throughout and at the first edge after release.
- Clean press (`DB_CYCLES=4`): `set_btn` 0→1 before E1, held for 20 cycles → `S=1` only in the cycle after E6; `state=1` from E6 onward; `R=0` and `conflict=0` throughout.
- Bounce: `clr_btn` toggles 1,0,1,0,1 on successive cycles, then holds 1 → `R` asserts exactly once, 6 edges after the final stable 1 is presented; no pulse from the bounce itself.
- Simultaneous: both buttons rise before the same edge with `state=1` → `conflict=1` for one cycle, `S=R=0` for the whole run, `state` stays 1.
- Staggered: `set_btn` rises, then `clr_btn` rises 2 cycles later → `S` pulse, then `R` pulse 2 cycles later; `state` goes 1 then 0; `S&R` is never 1.
- Reset mid-debounce: press `set_btn`, assert `rst=0` at E4, release reset at E5 with the button still held → no `S` before reset; one `S` pulse 6 edges after reset release.
